// File: rtl/alu_muldiv_unit_pkg.sv
// Shared constants for the RV32M multiply/divide unit: decode fields, funct codes and FSM states.
package alu_muldiv_unit_pkg;

  localparam logic [6:0] OPCODE_OP = 7'b0110011;
  localparam logic [6:0] MD_FUNCT7 = 7'b0000001;

  localparam logic [2:0] MUL_FUNCT3    = 3'b000;
  localparam logic [2:0] MULH_FUNCT3   = 3'b001;
  localparam logic [2:0] MULHSU_FUNCT3 = 3'b010;
  localparam logic [2:0] MULHU_FUNCT3  = 3'b011;
  localparam logic [2:0] DIV_FUNCT3    = 3'b100;
  localparam logic [2:0] DIVU_FUNCT3   = 3'b101;
  localparam logic [2:0] REM_FUNCT3    = 3'b110;
  localparam logic [2:0] REMU_FUNCT3   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic int md_cnt_width(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

  localparam int MD_CNT_WIDTH = md_cnt_width(32);

endpackage

// File: rtl/alu_muldiv_unit_if.sv
// EX-stage handshake between the pipeline (master) and the multiply/divide unit (slave).
interface alu_muldiv_unit_if #(
  parameter int XLEN       = 32,
  parameter int INST_WIDTH = 32
);
  logic                  in_valid;
  logic [INST_WIDTH-1:0] inst;
  logic [XLEN-1:0]       rs1_val;
  logic [XLEN-1:0]       rs2_val;
  logic                  flush;
  logic                  is_md;
  logic                  busy;
  logic                  out_valid;
  logic [XLEN-1:0]       result;

  modport master (
    output in_valid, inst, rs1_val, rs2_val, flush,
    input  is_md, busy, out_valid, result
  );

  modport slave (
    input  in_valid, inst, rs1_val, rs2_val, flush,
    output is_md, busy, out_valid, result
  );
endinterface

// File: rtl/alu_muldiv_unit_md_iter_core.sv
// Iteration registers for unsigned shift-add multiply and restoring divide, one bit per step.
// acc_nxt/rem_nxt show the value after the pending step so the caller can capture the final one.
module md_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0]   rem_nxt
);

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   opb;
  logic              div_mode;

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;
  logic [XLEN:0] rem_sel;
  logic          unused_rem_msb;

  // Partial remainder is XLEN+1 bits; its msb is always clear after the restore decision.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = {rem, acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
    rem_sel   = div_diff[XLEN] ? div_shift : div_diff;
    if (div_mode) begin
      acc_nxt = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ~div_diff[XLEN]};
      rem_nxt = rem_sel[XLEN-1:0];
    end else begin
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
      rem_nxt = rem;
    end
  end

  assign unused_rem_msb = rem_sel[XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      rem      <= '0;
      opb      <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      acc      <= {{XLEN{1'b0}}, a};
      rem      <= '0;
      opb      <= b;
      div_mode <= is_div;
    end else if (step) begin
      acc <= acc_nxt;
      rem <= rem_nxt;
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// RV32M execution unit beside the ALU: decode, sign conditioning, sequencing FSM and fast-path results.
//   state   | meaning
//   MD_IDLE | waiting for an M instruction; busy low
//   MD_CALC | one multiply/divide bit per cycle, down-counter from XLEN to terminal count 1
//   MD_DONE | result register holds the answer; out_valid pulse unless flushed
module alu_muldiv_unit
  import alu_muldiv_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INST_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  alu_muldiv_unit_if.slave bus
);

  localparam int CW = md_cnt_width(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [XLEN-1:0] result_q, res_nxt;
  logic [2:0]      f3_q;
  logic            neg_q;
  logic            res_load, core_load, core_step, out_valid;

  logic [2:0]      f3;
  logic            is_md, is_div, accept, sgn1, sgn2, s1, s2, neg, div0, ovf;
  logic [XLEN-1:0] mag1, mag2, fast_res, calc_res, div_raw, rem_nxt;
  logic [2*XLEN-1:0] acc_nxt, prod;
  logic            unused_inst;

  assign f3     = bus.inst[14:12];
  assign is_md  = (bus.inst[6:0] == OPCODE_OP) && (bus.inst[31:25] == MD_FUNCT7);
  assign is_div = f3[2];
  assign accept = (state == MD_IDLE) && bus.in_valid && is_md && !bus.flush;
  assign unused_inst = ^{bus.inst[24:15], bus.inst[11:7]};

  assign sgn1 = (f3 == MUL_FUNCT3) || (f3 == MULH_FUNCT3) || (f3 == MULHSU_FUNCT3) ||
                (f3 == DIV_FUNCT3) || (f3 == REM_FUNCT3);
  assign sgn2 = (f3 == MUL_FUNCT3) || (f3 == MULH_FUNCT3) ||
                (f3 == DIV_FUNCT3) || (f3 == REM_FUNCT3);
  assign s1   = sgn1 && bus.rs1_val[XLEN-1];
  assign s2   = sgn2 && bus.rs2_val[XLEN-1];
  assign mag1 = s1 ? -bus.rs1_val : bus.rs1_val;
  assign mag2 = s2 ? -bus.rs2_val : bus.rs2_val;
  // Remainder takes the dividend's sign; quotient and product take the xor.
  assign neg  = (is_div && f3[1]) ? s1 : (s1 ^ s2);

  assign div0 = is_div && (bus.rs2_val == '0);
  assign ovf  = ((f3 == DIV_FUNCT3) || (f3 == REM_FUNCT3)) &&
                (bus.rs1_val == SMIN) && (bus.rs2_val == '1);

  always_comb begin
    fast_res = '0;
    if (div0)
      fast_res = f3[1] ? bus.rs1_val : '1;
    else if (ovf)
      fast_res = f3[1] ? '0 : bus.rs1_val;
  end

  md_iter_core #(.XLEN(XLEN)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (core_load),
    .step    (core_step),
    .is_div  (is_div),
    .a       (mag1),
    .b       (mag2),
    .acc_nxt (acc_nxt),
    .rem_nxt (rem_nxt)
  );

  always_comb begin
    prod    = neg_q ? -acc_nxt : acc_nxt;
    div_raw = f3_q[1] ? rem_nxt : acc_nxt[XLEN-1:0];
    if (f3_q[2])
      calc_res = neg_q ? -div_raw : div_raw;
    else if (f3_q == MUL_FUNCT3)
      calc_res = prod[XLEN-1:0];
    else
      calc_res = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    core_load = 1'b0;
    core_step = 1'b0;
    res_load  = 1'b0;
    res_nxt   = calc_res;
    out_valid = 1'b0;
    case (state)
      MD_IDLE: begin
        if (accept) begin
          core_load = 1'b1;
          if (div0 || ovf) begin
            state_nxt = MD_DONE;
            res_load  = 1'b1;
            res_nxt   = fast_res;
          end else begin
            state_nxt = MD_CALC;
            cnt_nxt   = CW'(XLEN);
          end
        end
      end
      MD_CALC: begin
        core_step = 1'b1;
        cnt_nxt   = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state_nxt = MD_DONE;
          res_load  = 1'b1;
        end
      end
      MD_DONE: begin
        out_valid = 1'b1;
        state_nxt = MD_IDLE;
      end
      default: state_nxt = MD_IDLE;
    endcase
    if (bus.flush) begin
      state_nxt = MD_IDLE;
      cnt_nxt   = '0;
      core_load = 1'b0;
      res_load  = 1'b0;
      out_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      result_q <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (res_load)
        result_q <= res_nxt;
      if (core_load) begin
        f3_q  <= f3;
        neg_q <= neg;
      end
    end
  end

  assign bus.is_md     = is_md;
  assign bus.busy      = (state != MD_IDLE);
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;

endmodule
